// File: rtl/sd_cmd_arbiter.sv
`timescale 1ns/1ps
// Two-requester arbiter in front of the SD host command controller; owns the command timeout.
// Define SD_CMD_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module sd_cmd_arbiter #(
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        iClock_host,
    input  logic        iReset,
    input  logic        iReq0,
    input  logic        iReq1,
    input  logic [5:0]  iIndex0,
    input  logic [5:0]  iIndex1,
    input  logic [31:0] iArg0,
    input  logic [31:0] iArg1,
    output logic        oGrant0,
    output logic        oGrant1,
    output logic        oDone0,
    output logic        oDone1,
    output logic [47:0] oResponse,
    output logic        oIndexError,
    output logic        oTimedOut,
    output logic        oBusy,
    input  logic        iIdle,
    input  logic        iCommand_complete,
    input  logic [47:0] iResponse,
    input  logic        iCommand_index_error,
    output logic        oNew_command,
    output logic [5:0]  oCmd_index,
    output logic [31:0] oCmd_argument,
    output logic        oTimeout_enable,
    output logic        oTimeout
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] DRAIN     = 3'd4;
    localparam logic [2:0] REPORT    = 3'd5;

    // The pulse fires on the edge where the count steps to TIMEOUT_CYCLES-1.
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 2);

    logic [2:0]           state;
    logic [2:0]           nextState;
    logic [TIMEOUT_W-1:0] timeoutCount;
    logic                 grantedReq;
    logic                 anyReq;
    logic                 winner;
    logic                 timeoutHit;

    assign anyReq     = iReq0 | iReq1;
    assign timeoutHit = ((state == START) || (state == WAIT_DONE)) && (timeoutCount == TIMEOUT_LAST);

`ifdef SD_CMD_ARB_ROUND_ROBIN_EN
    logic rrPointer;

    assign winner = (iReq0 && iReq1) ? rrPointer : iReq1;

    always_ff @(posedge iClock_host) begin
        if (iReset)
            rrPointer <= 1'b0;
        else if (state == REPORT)
            rrPointer <= ~grantedReq;
    end
`else
    assign winner = ~iReq0;
`endif

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves nextState unassigned (no latch).
        nextState = state;
        case (state)
            IDLE:      if (anyReq) nextState = ISSUE;
            ISSUE:     if (iIdle) nextState = START;
            START:     if (timeoutHit) nextState = DRAIN;
                       else if (!iIdle) nextState = WAIT_DONE;
            WAIT_DONE: if (timeoutHit) nextState = DRAIN;
                       else if (iIdle && iCommand_complete) nextState = REPORT;
            DRAIN:     if (iIdle) nextState = REPORT;
            REPORT:    nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClock_host) begin
        if (iReset) begin
            state           <= IDLE;
            timeoutCount    <= '0;
            grantedReq      <= 1'b0;
            oGrant0         <= 1'b0;
            oGrant1         <= 1'b0;
            oDone0          <= 1'b0;
            oDone1          <= 1'b0;
            oResponse       <= '0;
            oIndexError     <= 1'b0;
            oTimedOut       <= 1'b0;
            oBusy           <= 1'b0;
            oNew_command    <= 1'b0;
            oCmd_index      <= '0;
            oCmd_argument   <= '0;
            oTimeout_enable <= 1'b0;
            oTimeout        <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; pulses default low and are raised for one edge below.
            state    <= nextState;
            oBusy    <= (nextState != IDLE);
            oGrant0  <= 1'b0;
            oGrant1  <= 1'b0;
            oDone0   <= 1'b0;
            oDone1   <= 1'b0;
            oTimeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (anyReq) begin
                        grantedReq      <= winner;
                        oGrant0         <= ~winner;
                        oGrant1         <= winner;
                        oCmd_index      <= winner ? iIndex1 : iIndex0;
                        oCmd_argument   <= winner ? iArg1 : iArg0;
                        oTimedOut       <= 1'b0;
                        oTimeout_enable <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (iIdle) timeoutCount <= '0;
                end
                START, WAIT_DONE: begin
                    if (timeoutHit) begin
                        oTimeout     <= 1'b1;
                        oTimedOut    <= 1'b1;
                        oResponse    <= '0;
                        oIndexError  <= 1'b0;
                        oNew_command <= 1'b0;
                    end else begin
                        timeoutCount <= timeoutCount + 1'b1;
                        if (state == START) begin
                            // Held until the controller is seen leaving idle.
                            oNew_command <= iIdle;
                        end else if (iIdle && iCommand_complete) begin
                            oResponse   <= iResponse;
                            oIndexError <= iCommand_index_error;
                        end
                    end
                end
                REPORT: begin
                    oDone0          <= ~grantedReq;
                    oDone1          <= grantedReq;
                    oTimeout_enable <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for sd_cmd_arbiter: a behavioural controller model plus transaction-level expectations.
module tb_sd_cmd_arbiter;

    localparam int TO_CYC = 8;
    localparam int BUDGET = 200;
`ifdef SD_CMD_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        iClock_host, iReset;
    logic        iReq0, iReq1;
    logic [5:0]  iIndex0, iIndex1;
    logic [31:0] iArg0, iArg1;
    logic        oGrant0, oGrant1, oDone0, oDone1;
    logic [47:0] oResponse;
    logic        oIndexError, oTimedOut, oBusy;
    logic        iIdle, iCommand_complete;
    logic [47:0] iResponse;
    logic        iCommand_index_error;
    logic        oNew_command;
    logic [5:0]  oCmd_index;
    logic [31:0] oCmd_argument;
    logic        oTimeout_enable, oTimeout;

    int nTests = 0;
    int nFail  = 0;
    int expPtr = 0;

    int          ctlLatency = 2;
    bit          ctlHang    = 0;
    bit          ctlRelease = 0;
    logic [47:0] ctlResp    = '0;

    int   nNewRise = 0, nTimeoutPulse = 0, timeoutWidth = 0, maxTimeoutWidth = 0;
    logic prevNew = 1'b0;

    sd_cmd_arbiter #(.TIMEOUT_W(16), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .iClock_host(iClock_host), .iReset(iReset),
        .iReq0(iReq0), .iReq1(iReq1),
        .iIndex0(iIndex0), .iIndex1(iIndex1),
        .iArg0(iArg0), .iArg1(iArg1),
        .oGrant0(oGrant0), .oGrant1(oGrant1), .oDone0(oDone0), .oDone1(oDone1),
        .oResponse(oResponse), .oIndexError(oIndexError), .oTimedOut(oTimedOut), .oBusy(oBusy),
        .iIdle(iIdle), .iCommand_complete(iCommand_complete), .iResponse(iResponse),
        .iCommand_index_error(iCommand_index_error),
        .oNew_command(oNew_command), .oCmd_index(oCmd_index), .oCmd_argument(oCmd_argument),
        .oTimeout_enable(oTimeout_enable), .oTimeout(oTimeout)
    );

    initial begin
        iClock_host = 1'b0;
        forever #5 iClock_host = ~iClock_host;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Controller model: leaves idle one cycle after seeing a new command, returns after ctlLatency cycles.
    // Its index-error flag mirrors response bit 46.
    initial begin
        iIdle = 1'b1; iCommand_complete = 1'b0; iResponse = '0; iCommand_index_error = 1'b0;
        forever begin
            @(negedge iClock_host);
            iCommand_complete = 1'b0;
            if (oNew_command === 1'b1 && iIdle && !iReset) begin
                iIdle = 1'b0;
                if (ctlHang) begin
                    while (!ctlRelease && !iReset) @(negedge iClock_host);
                    iIdle = 1'b1;
                end else begin
                    for (int i = 0; i < ctlLatency && !iReset; i++) @(negedge iClock_host);
                    iIdle = 1'b1;
                    if (!iReset) begin
                        iCommand_complete    = 1'b1;
                        iResponse            = ctlResp;
                        iCommand_index_error = ctlResp[46];
                    end
                end
            end
        end
    end

    always @(negedge iClock_host) begin
        if (oNew_command === 1'b1 && prevNew !== 1'b1) nNewRise++;
        prevNew = oNew_command;
        if (oTimeout === 1'b1) begin
            timeoutWidth++;
            if (timeoutWidth == 1) nTimeoutPulse++;
            if (timeoutWidth > maxTimeoutWidth) maxTimeoutWidth = timeoutWidth;
        end else begin
            timeoutWidth = 0;
        end
    end

    function automatic logic [95:0] outVec();
        return {oGrant0, oGrant1, oDone0, oDone1, oResponse, oIndexError, oTimedOut, oBusy,
                oNew_command, oCmd_index, oCmd_argument, oTimeout_enable, oTimeout};
    endfunction

    task automatic wait_grant(output int who, output int lat);
        who = -1; lat = BUDGET + 1;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge iClock_host);
            if (oGrant0 === 1'b1 || oGrant1 === 1'b1) begin
                who = (oGrant0 === 1'b1 && oGrant1 === 1'b1) ? 2 : ((oGrant1 === 1'b1) ? 1 : 0);
                lat = c;
                break;
            end
        end
    endtask

    task automatic wait_done(output int who, output int lat);
        who = -1; lat = BUDGET + 1;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge iClock_host);
            if (oDone0 === 1'b1 || oDone1 === 1'b1) begin
                who = (oDone0 === 1'b1 && oDone1 === 1'b1) ? 2 : ((oDone1 === 1'b1) ? 1 : 0);
                lat = c;
                break;
            end
        end
    endtask

    // sel 0: oNew_command high, 1: oTimeout high, 2: oNew_command low
    task automatic wait_sig(input int sel, output int lat);
        lat = BUDGET + 1;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge iClock_host);
            if ((sel == 0 && oNew_command === 1'b1) || (sel == 1 && oTimeout === 1'b1) ||
                (sel == 2 && oNew_command === 1'b0)) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int who, lat;
        iReset = 1'b1; iReq0 = 1'b1; iReq1 = 1'b0;
        iIndex0 = 6'd5; iArg0 = 32'hA5A5_0001; iIndex1 = 6'd0; iArg1 = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge iClock_host);
            nTests++;
            if (outVec() !== '0) begin
                nFail++; $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, outVec());
            end
        end
        iReset = 1'b0;
        wait_grant(who, lat);
        nTests++;
        if (who !== 0 || lat !== 1) begin
            nFail++; $display("FAIL reset_first_grant: got grant %0d after %0d cycles, expected grant 0 after 1", who, lat);
        end
        iReq0 = 1'b0;
        wait_done(who, lat);
        nTests++;
        if (who !== 0) begin nFail++; $display("FAIL reset_first_done: got %0d expected 0", who); end
        expPtr = 1;
    endtask

    task automatic test_single();
        int who, lat, rise0;
        rise0 = nNewRise;
        ctlLatency = 3; ctlResp = 48'h1100_0009_0001;
        iIndex0 = 6'd17; iArg0 = 32'h0000_0200; iReq0 = 1'b1;
        wait_grant(who, lat);
        iReq0 = 1'b0;
        nTests++;
        if (who !== 0 || lat !== 1 || oCmd_index !== 6'd17 || oCmd_argument !== 32'h0000_0200) begin
            nFail++; $display("FAIL single_grant: grant %0d lat %0d idx %0d arg %h, expected 0 1 17 00000200", who, lat, oCmd_index, oCmd_argument);
        end
        nTests++;
        if (oBusy !== 1'b1 || oTimeout_enable !== 1'b1) begin
            nFail++; $display("FAIL single_busy_en: busy %b ten %b, expected 1 1", oBusy, oTimeout_enable);
        end
        wait_sig(0, lat);
        nTests++;
        if (lat !== 2) begin nFail++; $display("FAIL single_newcmd_timing: rose after %0d cycles, expected 2", lat); end
        wait_done(who, lat);
        nTests++;
        if (who !== 0 || oResponse !== 48'h1100_0009_0001 || oIndexError !== 1'b0 || oTimedOut !== 1'b0) begin
            nFail++; $display("FAIL single_done: done %0d resp %h ie %b to %b, expected 0 110000090001 0 0", who, oResponse, oIndexError, oTimedOut);
        end
        nTests++;
        if (nNewRise - rise0 !== 1 || oBusy !== 1'b0 || oTimeout_enable !== 1'b0) begin
            nFail++; $display("FAIL single_after: bursts %0d busy %b ten %b, expected 1 0 0", nNewRise - rise0, oBusy, oTimeout_enable);
        end
        expPtr = 1;
    endtask

    task automatic test_index_error();
        int who, lat;
        ctlLatency = 2; ctlResp = 48'h4000_1234_5678 | 48'h0000_0000_0001;
        iIndex1 = 6'd9; iArg1 = 32'hDEAD_BEEF; iReq1 = 1'b1;
        wait_grant(who, lat);
        iReq1 = 1'b0;
        wait_done(who, lat);
        nTests++;
        if (who !== 1 || oIndexError !== 1'b1 || oResponse !== ctlResp) begin
            nFail++; $display("FAIL index_error_done: done %0d ie %b resp %h, expected 1 1 %h", who, oIndexError, oResponse, ctlResp);
        end
        expPtr = 0;
        repeat (3) @(negedge iClock_host);
        nTests++;
        if (oIndexError !== 1'b1) begin nFail++; $display("FAIL index_error_hold: got %b expected 1", oIndexError); end
    endtask

    task automatic test_timeout();
        int who, lat, p0;
        bit earlyDone;
        ctlHang = 1'b1; ctlRelease = 1'b0;
        p0 = nTimeoutPulse; maxTimeoutWidth = 0;
        iIndex1 = 6'd33; iArg1 = $urandom; iReq1 = 1'b1;
        wait_grant(who, lat);
        iReq1 = 1'b0;
        nTests++;
        if (who !== 1 || oIndexError !== 1'b1) begin
            nFail++; $display("FAIL timeout_grant: grant %0d ie %b, expected 1 1", who, oIndexError);
        end
        // START is entered one cycle after the grant, so the pulse lands 1+7 cycles after it.
        wait_sig(1, lat);
        nTests++;
        if (lat !== TO_CYC) begin nFail++; $display("FAIL timeout_timing: pulse after %0d cycles, expected %0d", lat, TO_CYC); end
        nTests++;
        if (oTimedOut !== 1'b1 || oNew_command !== 1'b0 || oResponse !== '0 || oIndexError !== 1'b0) begin
            nFail++; $display("FAIL timeout_state: to %b nc %b resp %h ie %b, expected 1 0 0 0", oTimedOut, oNew_command, oResponse, oIndexError);
        end
        earlyDone = 1'b0;
        repeat (5) begin
            @(negedge iClock_host);
            if (oDone0 === 1'b1 || oDone1 === 1'b1) earlyDone = 1'b1;
        end
        nTests++;
        if (earlyDone) begin nFail++; $display("FAIL timeout_drain: got done while controller busy, expected none"); end
        ctlRelease = 1'b1;
        wait_done(who, lat);
        nTests++;
        if (who !== 1 || oTimedOut !== 1'b1 || oResponse !== '0 || oIndexError !== 1'b0) begin
            nFail++; $display("FAIL timeout_done: done %0d to %b resp %h ie %b, expected 1 1 0 0", who, oTimedOut, oResponse, oIndexError);
        end
        nTests++;
        if (nTimeoutPulse - p0 !== 1 || maxTimeoutWidth !== 1) begin
            nFail++; $display("FAIL timeout_pulse: pulses %0d width %0d, expected 1 1", nTimeoutPulse - p0, maxTimeoutWidth);
        end
        expPtr = 0;
        @(negedge iClock_host);
        ctlHang = 1'b0; ctlRelease = 1'b0;
    endtask

    task automatic test_timeout_precedence();
        int who, lat;
        // Completion arrives on exactly the edge the counter expires.
        ctlLatency = 5; ctlResp = 48'h7FFF_0000_AAAA;
        iIndex0 = 6'd2; iArg0 = 32'h1; iReq0 = 1'b1;
        wait_grant(who, lat);
        iReq0 = 1'b0;
        wait_sig(1, lat);
        nTests++;
        if (lat !== TO_CYC) begin nFail++; $display("FAIL precedence_timing: pulse after %0d, expected %0d", lat, TO_CYC); end
        wait_done(who, lat);
        nTests++;
        if (who !== 0 || oTimedOut !== 1'b1 || oResponse !== '0 || oIndexError !== 1'b0) begin
            nFail++; $display("FAIL precedence_done: done %0d to %b resp %h ie %b, expected 0 1 0 0", who, oTimedOut, oResponse, oIndexError);
        end
        expPtr = 1;
        ctlLatency = 2;
    endtask

    task automatic test_simultaneous();
        int who, lat, expWho;
        iReset = 1'b1;
        repeat (2) @(negedge iClock_host);
        iReset = 1'b0;
        expPtr = 0;
        ctlLatency = 2; ctlResp = 48'h0000_0000_0C00;
        iIndex0 = 6'd1; iArg0 = 32'h0000_00A0; iIndex1 = 6'd2; iArg1 = 32'h0000_00B1;
        iReq0 = 1'b1; iReq1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            expWho = RR_EN ? expPtr : 0;
            wait_grant(who, lat);
            nTests++;
            if (who !== expWho || oCmd_index !== (expWho == 1 ? 6'd2 : 6'd1)) begin
                nFail++; $display("FAIL simultaneous_grant %0d: grant %0d idx %0d, expected %0d", n, who, oCmd_index, expWho);
            end
            wait_done(who, lat);
            if (n == 3) begin iReq0 = 1'b0; iReq1 = 1'b0; end
            nTests++;
            if (who !== expWho) begin
                nFail++; $display("FAIL simultaneous_done %0d: got %0d expected %0d", n, who, expWho);
            end
            expPtr = 1 - expWho;
        end
    endtask

    task automatic test_random();
        int who, lat, pattern, expWho;
        logic [5:0]  expIdx;
        logic [31:0] expArg;
        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge iClock_host);
            pattern    = $urandom_range(1, 3);
            ctlLatency = $urandom_range(1, 4);
            ctlResp    = {16'($urandom), 32'($urandom)};
            iIndex0 = 6'($urandom); iArg0 = $urandom;
            iIndex1 = 6'($urandom); iArg1 = $urandom;
            iReq0 = pattern[0]; iReq1 = pattern[1];
            if (pattern == 3) expWho = RR_EN ? expPtr : 0;
            else              expWho = (pattern == 2) ? 1 : 0;
            expIdx = (expWho == 1) ? iIndex1 : iIndex0;
            expArg = (expWho == 1) ? iArg1 : iArg0;
            wait_grant(who, lat);
            if (expWho == 1) iReq1 = 1'b0; else iReq0 = 1'b0;
            nTests++;
            if (who !== expWho || lat !== 1 || oCmd_index !== expIdx || oCmd_argument !== expArg) begin
                nFail++; $display("FAIL random_grant %0d: grant %0d lat %0d idx %0d arg %h, expected %0d 1 %0d %h",
                                  n, who, lat, oCmd_index, oCmd_argument, expWho, expIdx, expArg);
            end
            wait_done(who, lat);
            iReq0 = 1'b0; iReq1 = 1'b0;
            nTests++;
            if (who !== expWho || oResponse !== ctlResp || oIndexError !== ctlResp[46] || oTimedOut !== 1'b0) begin
                nFail++; $display("FAIL random_done %0d: done %0d resp %h ie %b to %b, expected %0d %h %b 0",
                                  n, who, oResponse, oIndexError, oTimedOut, expWho, ctlResp, ctlResp[46]);
            end
            expPtr = 1 - expWho;
        end
    endtask

    task automatic test_reset_in_wait();
        int who, lat;
        ctlLatency = 20; ctlResp = 48'h0000_0000_0F0F;
        iIndex0 = 6'd12; iArg0 = 32'h0000_1111; iReq0 = 1'b1;
        wait_grant(who, lat);
        iReq0 = 1'b0;
        wait_sig(0, lat);
        wait_sig(2, lat);
        iIndex1 = 6'd44; iArg1 = 32'hCAFE_0044; iReq1 = 1'b1;
        iReset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge iClock_host);
            nTests++;
            if (outVec() !== '0) begin
                nFail++; $display("FAIL reset_wait_outputs cycle %0d: got %h expected 0", c, outVec());
            end
        end
        iReset = 1'b0;
        ctlLatency = 2;
        expPtr = 0;
        wait_grant(who, lat);
        iReq1 = 1'b0;
        nTests++;
        if (who !== 1 || lat !== 1 || oCmd_index !== 6'd44 || oCmd_argument !== 32'hCAFE_0044) begin
            nFail++; $display("FAIL reset_wait_grant: grant %0d lat %0d idx %0d arg %h, expected 1 1 44 cafe0044", who, lat, oCmd_index, oCmd_argument);
        end
        wait_done(who, lat);
        nTests++;
        if (who !== 1 || oResponse !== 48'h0000_0000_0F0F) begin
            nFail++; $display("FAIL reset_wait_done: done %0d resp %h, expected 1 000000000f0f", who, oResponse);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_index_error();
        test_timeout();
        test_timeout_precedence();
        test_simultaneous();
        test_random();
        test_reset_in_wait();
        repeat (2) @(negedge iClock_host);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
